// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control sequencer.
// Steps one ALU and one unified memory through IF/ID/EX/MEM/WB.
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       alu_bcond,
  input  logic       halt_cond,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] wb_sel,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       pc_source,
  output logic       is_halted,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_ECALL = 7'b1110011;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_BR  = 2'd1;
  localparam logic [1:0] ALU_FN  = 2'd2;

  state_t cur, nxt;

  logic is_r, is_i, is_ld, is_st;
  logic is_br, is_jal, is_jalr, is_ecall;
  logic is_exec;

  assign is_r     = (opcode == OP_R);
  assign is_i     = (opcode == OP_I);
  assign is_ld    = (opcode == OP_LOAD);
  assign is_st    = (opcode == OP_STORE);
  assign is_br    = (opcode == OP_BR);
  assign is_jal   = (opcode == OP_JAL);
  assign is_jalr  = (opcode == OP_JALR);
  assign is_ecall = (opcode == OP_ECALL);
  assign is_exec  = is_r | is_i | is_ld | is_st
                  | is_br | is_jal | is_jalr;

  assign state = cur;

  // Next-state selection from current state, opcode and handshakes
  always_comb begin
    nxt = S_IF;
    unique case (cur)
      S_IF:   nxt = mem_ready ? S_ID : S_IF;
      S_ID: begin
        if (is_ecall)
          nxt = halt_cond ? S_HALT : S_IF;
        else if (is_exec)
          nxt = S_EX;
        else
          nxt = S_IF;
      end
      S_EX: begin
        if (is_ld | is_st)
          nxt = S_MEM;
        else if (is_r | is_i)
          nxt = S_WB;
        else
          nxt = S_IF;
      end
      S_MEM: begin
        if (!mem_ready)
          nxt = S_MEM;
        else
          nxt = is_ld ? S_WB : S_IF;
      end
      S_WB:   nxt = S_IF;
      S_HALT: nxt = S_HALT;
      default: nxt = S_IF;
    endcase
  end

  // State register; reset from any state returns to fetch
  always_ff @(posedge clk) begin
    if (reset)
      cur <= S_IF;
    else
      cur <= nxt;
  end

  // Datapath controls decoded per state; enables forced low in reset
  always_comb begin
    pc_write  = 1'b0;
    ir_write  = 1'b0;
    i_or_d    = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    wb_sel    = 2'd0;
    alu_src_a = 2'd0;
    alu_src_b = 2'd0;
    alu_op    = ALU_ADD;
    pc_source = 1'b0;
    is_halted = 1'b0;
    unique case (cur)
      S_IF: begin
        mem_read  = 1'b1;
        alu_src_a = 2'd2;
        alu_src_b = 2'd1;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_ID: begin
        alu_src_b = 2'd2;
      end
      S_EX: begin
        unique case (1'b1)
          is_r: begin
            alu_src_a = 2'd1;
            alu_op    = ALU_FN;
          end
          is_i: begin
            alu_src_a = 2'd1;
            alu_src_b = 2'd2;
            alu_op    = ALU_FN;
          end
          is_ld, is_st: begin
            alu_src_a = 2'd1;
            alu_src_b = 2'd2;
          end
          is_br: begin
            alu_src_a = 2'd1;
            alu_op    = ALU_BR;
            pc_source = 1'b1;
            pc_write  = alu_bcond;
          end
          is_jal: begin
            pc_write  = 1'b1;
            pc_source = 1'b1;
            reg_write = 1'b1;
            wb_sel    = 2'd2;
          end
          is_jalr: begin
            alu_src_a = 2'd1;
            alu_src_b = 2'd2;
            pc_write  = 1'b1;
            reg_write = 1'b1;
            wb_sel    = 2'd2;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        i_or_d    = 1'b1;
        alu_src_a = 2'd1;
        alu_src_b = 2'd2;
        mem_read  = is_ld;
        mem_write = is_st;
      end
      S_WB: begin
        reg_write = 1'b1;
        wb_sel    = is_ld ? 2'd1 : 2'd0;
      end
      S_HALT: begin
        is_halted = 1'b1;
      end
      default: ;
    endcase
    if (reset) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
      is_halted = 1'b0;
    end
  end

endmodule
